// File: rtl/sub_shift_rows.sv
// rtl/sub_shift_rows.sv - iterative AES-128 SubBytes + ShiftRows stage, one column per cycle

// Forward AES S-box lookup.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Table entry a sits at bit offset 8*a of the big-endian table vector.
    always_comb begin
        y = SBOX_TABLE[{a, 3'b000} +: 8];
    end

endmodule

module sub_shift_rows (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [0:127] src;
    logic [0:127] dst;
    logic [1:0]   col;

    logic [7:0]   sub_in  [4];
    logic [7:0]   sub_out [4];
    logic [6:0]   dst_bit [4];

    // Select the current source column and each row's ShiftRows destination.
    // Row r of column c lands in column (c - r) mod 4, which the 2-bit wrap gives for free.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            sub_in[r]  = src[{col, 2'(r), 3'b000} +: 8];
            dst_bit[r] = {col - 2'(r), 2'(r), 3'b000};
        end
    end

    for (genvar g = 0; g < 4; g++) begin : gen_sbox
        aes_sbox u_sbox (
            .a (sub_in[g]),
            .y (sub_out[g])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, four SUB cycles, hold in DONE until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = SUB;
            SUB:  if (col == 2'd3) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch the block on accept, then substitute one column per SUB cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src <= '0;
            dst <= '0;
            col <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        src <= in_data;
                        col <= 2'd0;
                    end
                end
                SUB: begin
                    for (int r = 0; r < 4; r++) begin
                        dst[dst_bit[r] +: 8] <= sub_out[r];
                    end
                    col <= col + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake outputs are decoded from state alone.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        out_data  = dst;
    end

endmodule
